// File: rtl/wb_pkg.sv
// Shared types and default sizing for the Wishbone master port and its watchdog.
package wb_pkg;

    localparam int WB_DATA_WIDTH     = 32;
    localparam int WB_TIMEOUT_CYCLES = 16;
    localparam int WB_SEL_WIDTH      = WB_DATA_WIDTH / 8;
    localparam int WB_TIMEOUT_W      = $clog2(WB_TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_ACK = 2'd2,
        RESP     = 2'd3
    } wb_state_t;

endpackage

// File: rtl/wb_watchdog.sv
// Bus-cycle watchdog: cleared when a request is accepted, counts while the cycle is open.
// o_expired marks the last bus cycle so the error response lands LIMIT cycles after accept.
module wb_watchdog import wb_pkg::*; #(
    parameter int LIMIT = WB_TIMEOUT_CYCLES,
    parameter int W     = WB_TIMEOUT_W
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    // r_count holds the number of open-cycle clocks before the current one.
    localparam logic [W-1:0] EXPIRE_AT = W'(LIMIT - 2);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != EXPIRE_AT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = i_enable && (r_count == EXPIRE_AT);

endmodule

// File: rtl/wb_master_port.sv
// Wishbone B4 pipelined initiator: one single-word bus cycle per accepted CPU request.
// Define WB_MASTER_TIMEOUT_EN to build the watchdog that ends unanswered cycles with an error.
module wb_master_port import wb_pkg::*; #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = WB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic                      i_req_we,
    input  logic [ADDR_WIDTH-1:0]     i_req_addr,
    input  logic [DATA_WIDTH-1:0]     i_req_data,
    input  logic [DATA_WIDTH/8-1:0]   i_req_sel,
    output logic                      o_rsp_valid,
    output logic [DATA_WIDTH-1:0]     o_rsp_data,
    output logic                      o_rsp_err,
    output logic                      o_wb_cyc,
    output logic                      o_wb_stb,
    output logic                      o_wb_we,
    output logic [ADDR_WIDTH-1:0]     o_wb_addr,
    output logic [DATA_WIDTH-1:0]     o_wb_data,
    output logic [DATA_WIDTH/8-1:0]   o_wb_sel,
    input  logic                      i_wb_ack,
    input  logic                      i_wb_stall,
    input  logic [DATA_WIDTH-1:0]     i_wb_data,
    output wb_state_t                 o_dbg_state
);

    // CPU side: request transfers when i_req_valid && o_req_ready; o_rsp_valid is a
    // one-cycle pulse with no back-pressure. Bus side: stb is taken when !i_wb_stall,
    // and an ack counts only in WAIT_ACK or on the non-stalled stb cycle.

    wb_state_t                 r_state;
    wb_state_t                 w_next_state;
    logic                      w_accept;
    logic                      w_ack_done;
    logic                      w_timeout;
    logic                      r_we;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [DATA_WIDTH-1:0]     r_data;
    logic [DATA_WIDTH/8-1:0]   r_sel;
    logic [DATA_WIDTH-1:0]     r_rsp_data;

    assign w_accept   = i_req_valid && (r_state == IDLE);
    assign w_ack_done = i_wb_ack &&
                        (((r_state == REQ) && !i_wb_stall) || (r_state == WAIT_ACK));

`ifdef WB_MASTER_TIMEOUT_EN
    logic w_expired;
    logic r_rsp_err;

    wb_watchdog #(
        .LIMIT (TIMEOUT_CYCLES),
        .W     ($clog2(TIMEOUT_CYCLES + 1))
    ) u_watchdog (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (w_accept),
        .i_enable  (o_wb_cyc),
        .o_expired (w_expired)
    );

    // A late ack arriving on the expiry cycle still completes normally.
    assign w_timeout = w_expired && !w_ack_done;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rsp_err <= 1'b0;
        end else if (w_ack_done) begin
            r_rsp_err <= 1'b0;
        end else if (w_timeout) begin
            r_rsp_err <= 1'b1;
        end
    end

    assign o_rsp_err = r_rsp_err;
`else
    assign w_timeout = 1'b0;
    assign o_rsp_err = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:     if (w_accept) w_next_state = REQ;
            REQ: begin
                if (w_ack_done || w_timeout) begin
                    w_next_state = RESP;
                end else if (!i_wb_stall) begin
                    w_next_state = WAIT_ACK;
                end
            end
            WAIT_ACK: if (w_ack_done || w_timeout) w_next_state = RESP;
            RESP:     w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
            r_sel  <= '0;
        end else if (w_accept) begin
            r_we   <= i_req_we;
            r_addr <= i_req_addr;
            r_data <= i_req_data;
            r_sel  <= i_req_sel;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rsp_data <= '0;
        end else if (w_ack_done) begin
            r_rsp_data <= r_we ? '0 : i_wb_data;
        end else if (w_timeout) begin
            r_rsp_data <= '0;
        end
    end

    assign o_req_ready = (r_state == IDLE);
    assign o_wb_cyc    = (r_state == REQ) || (r_state == WAIT_ACK);
    assign o_wb_stb    = (r_state == REQ);
    assign o_rsp_valid = (r_state == RESP);
    assign o_rsp_data  = r_rsp_data;
    assign o_wb_we     = r_we;
    assign o_wb_addr   = r_addr;
    assign o_wb_data   = r_data;
    assign o_wb_sel    = r_sel;
    assign o_dbg_state = r_state;

endmodule

// File: doc/wb_master_port.md
Name: wb_master_port

Overview:
- Wishbone pipelined-mode initiator (B4) that turns single CPU load/store requests into one bus cycle each, targeting main_memory or any compatible slave.
- Sits between the multi-cycle CPU core's memory-access stage and the Wishbone slave.
- Handles one outstanding transaction, slave stall, slave ack and an optional watchdog timeout.

Parameters:
- ADDR_WIDTH, 10, Wishbone word-address width (matches 1024-word memory).
- DATA_WIDTH, 32, data bus width; sel width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 16, watchdog limit in cycles; used only when the macro is defined.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_req_valid  in  1  CPU request valid.
- o_req_ready  out  1  high only in IDLE; a request is accepted when valid & ready.
- i_req_we  in  1  1 = write, 0 = read.
- i_req_addr  in  ADDR_WIDTH  target address.
- i_req_data  in  DATA_WIDTH  write data.
- i_req_sel  in  DATA_WIDTH/8  byte lane enables.
- o_rsp_valid  out  1  one-cycle pulse when the transaction completes.
- o_rsp_data  out  DATA_WIDTH  read data; 0 for writes and errors.
- o_rsp_err  out  1  timeout error, qualified by o_rsp_valid.
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone control.
- o_wb_addr  out  ADDR_WIDTH  Wishbone address.
- o_wb_data  out  DATA_WIDTH  Wishbone write data.
- o_wb_sel  out  DATA_WIDTH/8  Wishbone byte select.
- i_wb_ack, i_wb_stall  in  1 each  slave acknowledge and stall.
- i_wb_data  in  DATA_WIDTH  slave read data.

Behaviour:
- Reset: synchronous and active-low. At the edge where i_rst_n=0, all outputs clear to 0 except o_req_ready=1, and the state returns to IDLE. Reset mid-transaction drops cyc/stb on the next edge and produces no response.
- Request capture: on acceptance, i_req_we/addr/data/sel are registered onto o_wb_*. Later changes on i_req_* are ignored.
- IDLE: ready=1, cyc=stb=0. On accept, go to REQ and drive cyc=stb=1 from the next cycle.
- REQ: cyc=stb=1.
  - stall=1: hold all bus signals and stay in REQ.
  - stall=0 and ack=0: go to WAIT_ACK (stb=0, cyc=1).
  - stall=0 and ack=1 (same-cycle ack): go to RESP directly.
  - ack while stall=1 is ignored.
- WAIT_ACK: cyc=1, stb=0. On ack, go to RESP.
- Ack capture: on the ack cycle, o_rsp_data <= i_wb_data for reads, 0 for writes.
- RESP: cyc=stb=0, o_rsp_valid=1 for exactly one cycle, then IDLE.
- Latency: minimum accept-to-rsp_valid is 2 cycles (zero-wait slave with same-cycle ack).
- Back-to-back: the next request can be accepted the cycle after RESP.
- cyc falls on the cycle after ack, so it is never held across transactions.
- Unsolicited ack in IDLE or RESP: ignored.

Optional Feature:
- Macro WB_MASTER_TIMEOUT_EN.
- Defined: a counter clears on accept and increments each cycle in REQ/WAIT_ACK. When it reaches TIMEOUT_CYCLES with no ack:
  - drop cyc/stb and enter RESP with o_rsp_err=1 and o_rsp_data=0;
  - an ack in that same cycle takes priority (normal completion, err=0).
- Undefined: no counter is built, o_rsp_err is tied to 0, and the master waits for ack indefinitely.

Decomposition:
- Package wb_pkg holds:
  - state enum {IDLE, REQ, WAIT_ACK, RESP}, 2 bits;
  - localparam WB_SEL_WIDTH = DATA_WIDTH/8;
  - localparam WB_TIMEOUT_W = $clog2(TIMEOUT_CYCLES+1).
- One sub-module is natural: wb_watchdog (counter with clear, enable and expired output). It is instantiated only under WB_MASTER_TIMEOUT_EN.

Test Plan:
- Write, zero-wait slave: req we=1 addr=0x000 data=0xAABBCCDD sel=0xF.
  - Expect cyc/stb high the cycle after accept with o_wb_data=0xAABBCCDD.
  - Expect rsp_valid 2 cycles after accept, err=0, rsp_data=0.
- Read-back: req we=0 addr=0x000 after the write.
  - Expect o_rsp_data=0xAABBCCDD and a single-cycle rsp_valid.
- Stall: slave holds stall=1 for 3 cycles.
  - Expect stb/addr/sel stable for all 3 cycles, stb dropping after the first stall=0 cycle, ready=0 throughout.
- Delayed ack: ack 4 cycles after stb accepted.
  - Expect cyc=1 and stb=0 while waiting, cyc=0 the cycle after ack.
- Reset mid-transaction: assert i_rst_n=0 while in WAIT_ACK.
  - Expect cyc=stb=0 and ready=1 after the edge, no rsp_valid pulse.
- Timeout (macro on, TIMEOUT_CYCLES=16): slave never acks.
  - Expect rsp_valid with err=1 and rsp_data=0 16 cycles after accept, and cyc=0.
  - Macro off: cyc stays high for 100+ cycles.
